// File: rtl/core_dbg_pkg.sv
// Shared types and constants for the core run-control (halt) logic.
// Channel config fields are sized to the widest supported build and zero-extended on write.
package core_dbg_pkg;

    localparam int BP_ADDR_W = 64;
    localparam int BP_CNT_W  = 16;
    localparam int BP_DLY_W  = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ARMED  = ST_ARMED,
        DRAIN  = ST_DRAIN,
        HALTED = ST_HALTED
    } halt_state_e;

    localparam logic [1:0] HALT_NONE = 2'd0;
    localparam logic [1:0] HALT_BP   = 2'd1;
    localparam logic [1:0] HALT_TMO  = 2'd2;

    typedef struct packed {
        logic                 en;
        logic [BP_ADDR_W-1:0] addr;
        logic [BP_CNT_W-1:0]  cnt;
        logic [BP_DLY_W-1:0]  dly;
    } bp_cfg_t;

    // A programmed threshold of zero behaves as one.
    function automatic logic [BP_CNT_W-1:0] effThr(input logic [BP_CNT_W-1:0] c);
        return (c == '0) ? BP_CNT_W'(1) : c;
    endfunction

endpackage

// File: rtl/core_halt_ctrl_bp_channel.sv
// One breakpoint channel: config register, PC comparator and saturating hit counter.
module bp_channel
    import core_dbg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfgWe,
    input  bp_cfg_t             cfgIn,
    input  logic                clrCnt,
    input  logic                countEn,
    input  logic [XLEN-1:0]     pc,
    input  logic                pcValid,
    output logic                match,
    output logic                trig,
    output logic [BP_DLY_W-1:0] dly
);

    bp_cfg_t          cfg;
    logic [CNT_W-1:0] hitCnt;
    logic [CNT_W-1:0] nextCnt;
    logic             sat;

    assign nextCnt = hitCnt + 1'b1;
    assign sat     = &hitCnt;
    assign match   = pcValid && cfg.en && (cfg.addr == BP_ADDR_W'(pc));
    // Fires only on the match that brings the count up to the threshold.
    assign trig    = match && countEn && !sat && (BP_CNT_W'(nextCnt) == effThr(cfg.cnt));
    assign dly     = cfg.dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg    <= '0;
            hitCnt <= '0;
        end else begin
            if (cfgWe)
                cfg <= cfgIn;
            if (clrCnt)
                hitCnt <= '0;
            else if (match && countEn && !sat)
                hitCnt <= nextCnt;
        end
    end

endmodule

// File: rtl/core_halt_ctrl.sv
// Breakpoint/timeout run-control: raises a sticky halt after a channel trigger plus delay.
// Optional cycle-timeout watchdog is built when CORE_HALT_TIMEOUT_EN is defined.
module core_halt_ctrl
    import core_dbg_pkg::*;
#(
    parameter  int NUM_BP = 4,
    parameter  int XLEN   = 32,
    parameter  int CNT_W  = 8,
    parameter  int DLY_W  = 4,
    parameter  int TMO_W  = 16,
    localparam int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc,
    input  logic              pc_valid,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic [XLEN-1:0]   cfg_addr,
    input  logic [CNT_W-1:0]  cfg_cnt,
    input  logic [DLY_W-1:0]  cfg_dly,
    input  logic [TMO_W-1:0]  tmo_limit,
    input  logic              arm,
    input  logic              resume,
    output logic              halt,
    output logic [1:0]        halt_cause,
    output logic [IDX_W-1:0]  bp_idx,
    output logic [NUM_BP-1:0] hit_vec,
    output logic              busy
);

    halt_state_e          state;
    logic [BP_DLY_W-1:0]  dlyCnt;
    logic [NUM_BP-1:0]    matchVec;
    logic [NUM_BP-1:0]    trigVec;
    logic [BP_DLY_W-1:0]  chDly [NUM_BP];
    bp_cfg_t              cfgIn;
    logic                 cfgOpen;
    logic                 countEn;
    logic                 armNow;
    logic                 trigAny;
    logic [IDX_W-1:0]     firstIdx;
    logic [BP_DLY_W-1:0]  firstDly;
    logic                 tmoHit;
    logic                 unusedMatch;

    assign cfgIn   = '{en: cfg_en, addr: BP_ADDR_W'(cfg_addr),
                       cnt: BP_CNT_W'(cfg_cnt), dly: BP_DLY_W'(cfg_dly)};
    assign cfgOpen = (state == IDLE) || (state == HALTED);
    assign countEn = (state == ARMED) || (state == DRAIN);
    assign armNow  = (state == IDLE) && arm;
    assign busy    = countEn;
    assign unusedMatch = ^matchVec;

    for (genvar g = 0; g < NUM_BP; g++) begin : gCh
        bp_channel #(.XLEN(XLEN), .CNT_W(CNT_W)) uCh (
            .clk     (clk),
            .rst     (rst),
            .cfgWe   (cfg_we && cfgOpen && (cfg_idx == IDX_W'(g))),
            .cfgIn   (cfgIn),
            .clrCnt  (armNow),
            .countEn (countEn),
            .pc      (pc),
            .pcValid (pc_valid),
            .match   (matchVec[g]),
            .trig    (trigVec[g]),
            .dly     (chDly[g])
        );
    end

    always_comb begin
        trigAny  = 1'b0;
        firstIdx = '0;
        firstDly = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (trigVec[i] && !trigAny) begin
                trigAny  = 1'b1;
                firstIdx = IDX_W'(i);
                firstDly = chDly[i];
            end
        end
    end

`ifdef CORE_HALT_TIMEOUT_EN
    logic [TMO_W-1:0] cycleCnt;

    // Counts completed ARMED cycles; the cycle that completes the limit halts.
    assign tmoHit = (tmo_limit != '0) && (cycleCnt == tmo_limit - 1'b1);

    always_ff @(posedge clk) begin
        if (rst)
            cycleCnt <= '0;
        else if (armNow)
            cycleCnt <= '0;
        else if ((state == ARMED) && !(&cycleCnt))
            cycleCnt <= cycleCnt + 1'b1;
    end
`else
    logic unusedTmo;
    assign tmoHit    = 1'b0;
    assign unusedTmo = ^tmo_limit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dlyCnt     <= '0;
            halt       <= 1'b0;
            halt_cause <= HALT_NONE;
            bp_idx     <= '0;
            hit_vec    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        hit_vec    <= '0;
                        halt_cause <= HALT_NONE;
                        state      <= ARMED;
                    end
                end
                ARMED: begin
                    hit_vec <= hit_vec | trigVec;
                    if (trigAny) begin
                        bp_idx <= firstIdx;
                        dlyCnt <= firstDly;
                        state  <= DRAIN;
                    end else if (tmoHit) begin
                        halt       <= 1'b1;
                        halt_cause <= HALT_TMO;
                        state      <= HALTED;
                    end
                end
                DRAIN: begin
                    hit_vec <= hit_vec | trigVec;
                    if (dlyCnt == '0) begin
                        halt       <= 1'b1;
                        halt_cause <= HALT_BP;
                        state      <= HALTED;
                    end else begin
                        dlyCnt <= dlyCnt - 1'b1;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        halt  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_halt_ctrl.sv
// Scoreboard bench for core_halt_ctrl: expected halt events are queued by the stimulus
// and checked by a monitor on every rising edge of halt.
module tb_core_halt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_en;
    logic [31:0] cfg_addr;
    logic [7:0]  cfg_cnt;
    logic [3:0]  cfg_dly;
    logic [15:0] tmo_limit;
    logic        arm;
    logic        resume;
    logic        halt;
    logic [1:0]  halt_cause;
    logic [1:0]  bp_idx;
    logic [3:0]  hit_vec;
    logic        busy;

    core_halt_ctrl #(.NUM_BP(4), .XLEN(32), .CNT_W(8), .DLY_W(4), .TMO_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_en     (cfg_en),
        .cfg_addr   (cfg_addr),
        .cfg_cnt    (cfg_cnt),
        .cfg_dly    (cfg_dly),
        .tmo_limit  (tmo_limit),
        .arm        (arm),
        .resume     (resume),
        .halt       (halt),
        .halt_cause (halt_cause),
        .bp_idx     (bp_idx),
        .hit_vec    (hit_vec),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         edgeN;
        logic [1:0] cause;
        logic [1:0] idx;
        logic [3:0] hv;
    } exp_t;

    exp_t sb[$];
    exp_t mon;
    int   checks   = 0;
    int   failures = 0;
    logic prevHalt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (halt === 1'b1 && prevHalt !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_halt actual=halt at cycle %0d required=no halt", cyc);
            end else begin
                mon = sb.pop_front();
                chk("halt_edge", cyc, mon.edgeN);
                chk("halt_cause", {30'd0, halt_cause}, {30'd0, mon.cause});
                chk("bp_idx", {30'd0, bp_idx}, {30'd0, mon.idx});
                chk("hit_vec", {28'd0, hit_vec}, {28'd0, mon.hv});
            end
        end
        prevHalt <= halt;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfgWrite(input logic [1:0] idx, input logic en, input logic [31:0] addr,
                            input logic [7:0] cnt, input logic [3:0] dly);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_addr = addr; cfg_cnt = cnt; cfg_dly = dly;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulseArm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulseResume();
        resume = 1'b1;
        tick();
        resume = 1'b0;
    endtask

    // Match sampled at the next edge t = cyc+1; halt expected at edge t+1+dly.
    task automatic passPc(input logic [31:0] a, input bit push, input int dly,
                          input logic [1:0] cause, input logic [1:0] idx, input logic [3:0] hv);
        exp_t e;
        if (push) begin
            e = '{cyc + 2 + dly, cause, idx, hv};
            sb.push_back(e);
        end
        pc = a;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
    endtask

    task automatic waitHalt(input string name, input int budget);
        int n = 0;
        while (halt !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(name, {31'd0, halt}, 32'd1);
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_halt"}, {31'd0, halt}, 32'd0);
        chk({tag, "_cause"}, {30'd0, halt_cause}, 32'd0);
        chk({tag, "_bpidx"}, {30'd0, bp_idx}, 32'd0);
        chk({tag, "_hitvec"}, {28'd0, hit_vec}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=time limit reached required=bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc = '0; pc_valid = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
        cfg_addr = '0; cfg_cnt = '0; cfg_dly = '0; tmo_limit = '0; arm = 1'b0; resume = 1'b0;
        tick(3);
        chkReset("reset");
        rst = 1'b0;
        tick();

        // Single-hit breakpoint, zero delay.
        cfgWrite(2'd0, 1'b1, 32'h174, 8'd1, 4'd0);
        pulseArm();
        chk("busy_armed", {31'd0, busy}, 32'd1);
        tick(5);
        passPc(32'h174, 1, 0, 2'd1, 2'd0, 4'b0001);
        waitHalt("t1_halt", 5);
        chk("busy_halted", {31'd0, busy}, 32'd0);
        pulseResume();
        chk("t1_resume_halt", {31'd0, halt}, 32'd0);

        // Threshold 3 with delay 6.
        cfgWrite(2'd2, 1'b1, 32'hFC, 8'd3, 4'd6);
        pulseArm();
        tick(2);
        passPc(32'hFC, 0, 0, 2'd0, 2'd0, 4'b0);
        tick(3);
        passPc(32'hFC, 0, 0, 2'd0, 2'd0, 4'b0);
        tick(3);
        passPc(32'hFC, 1, 6, 2'd1, 2'd2, 4'b0100);
        chk("busy_drain", {31'd0, busy}, 32'd1);
        waitHalt("t2_halt", 12);
        pulseResume();

        // Simultaneous triggers: ch1 (cnt 0 acts as 1, dly 2) beats ch3 (dly 0).
        cfgWrite(2'd1, 1'b1, 32'h328, 8'd0, 4'd2);
        cfgWrite(2'd3, 1'b1, 32'h328, 8'd1, 4'd0);
        pulseArm();
        tick(2);
        passPc(32'h328, 1, 2, 2'd1, 2'd1, 4'b1010);
        waitHalt("t3_halt", 8);
        pulseResume();
        chk("hitvec_kept", {28'd0, hit_vec}, 32'b1010);
        chk("cause_kept", {30'd0, halt_cause}, 32'd1);
        chk("bpidx_kept", {30'd0, bp_idx}, 32'd1);

        // Config write while armed is ignored; old ch0 address still triggers.
        pulseArm();
        tick();
        cfgWrite(2'd0, 1'b1, 32'h200, 8'd1, 4'd0);
        tick(2);
        passPc(32'h200, 0, 0, 2'd0, 2'd0, 4'b0);
        tick(4);
        chk("ignored_cfg_no_halt", {31'd0, halt}, 32'd0);
        passPc(32'h174, 1, 0, 2'd1, 2'd0, 4'b0001);
        waitHalt("t4_halt", 5);
        pulseResume();
        chk("t4_resume_halt", {31'd0, halt}, 32'd0);
        pulseArm();
        chk("rearm_busy", {31'd0, busy}, 32'd1);
        tick();
        passPc(32'h174, 1, 0, 2'd1, 2'd0, 4'b0001);
        waitHalt("t4b_halt", 5);
        pulseResume();

        // Reset during DRAIN: halt never rises.
        cfgWrite(2'd0, 1'b1, 32'h400, 8'd1, 4'd8);
        pulseArm();
        tick();
        passPc(32'h400, 0, 0, 2'd0, 2'd0, 4'b0);
        tick(3);
        chk("t5_busy_drain", {31'd0, busy}, 32'd1);
        chk("t5_hitvec_drain", {28'd0, hit_vec}, 32'b0001);
        rst = 1'b1;
        tick();
        chkReset("mid_drain_reset");
        rst = 1'b0;
        tick(15);
        chk("t5_no_halt", {31'd0, halt}, 32'd0);

        // Timeout watchdog.
        tmo_limit = 16'd250;
`ifdef CORE_HALT_TIMEOUT_EN
        begin
            exp_t e;
            e = '{cyc + 251, 2'd2, 2'd0, 4'b0};
            sb.push_back(e);
        end
        pulseArm();
        waitHalt("tmo_halt", 300);
        pulseResume();
        tmo_limit = 16'd0;
        pulseArm();
        tick(400);
        chk("tmo_disabled_no_halt", {31'd0, halt}, 32'd0);
        chk("tmo_disabled_busy", {31'd0, busy}, 32'd1);
`else
        pulseArm();
        tick(300);
        chk("no_tmo_build_no_halt", {31'd0, halt}, 32'd0);
        chk("no_tmo_build_busy", {31'd0, busy}, 32'd1);
`endif

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
